// File: rtl/data_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding, grant owner ids, default widths.
package data_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_IO   = 1'b1
    } owner_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory request port.
// slave = arbiter view, master = requesters + memory view.
interface data_mem_arbiter_if
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              core_mode;

    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_done;
    logic [DATA_W-1:0] core_rdata;

    logic              io_req;
    logic              io_we;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              io_done;
    logic [DATA_W-1:0] io_rdata;

    logic              mem_valid;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_ready;

    modport slave (
        input  core_mode,
        input  core_req, core_we, core_addr, core_wdata,
        output core_done, core_rdata,
        input  io_req, io_we, io_addr, io_wdata,
        output io_done, io_rdata,
        output mem_valid, mem_rw, mem_addr, mem_din,
        input  mem_dout, mem_ready
    );

    modport master (
        output core_mode,
        output core_req, core_we, core_addr, core_wdata,
        input  core_done, core_rdata,
        output io_req, io_we, io_addr, io_wdata,
        input  io_done, io_rdata,
        input  mem_valid, mem_rw, mem_addr, mem_din,
        output mem_dout, mem_ready
    );

endinterface

// File: rtl/data_mem_arbiter_pick.sv
// Winner select between core and IO with a starvation counter; owner is combinational,
// the counter advances only on a grant (fire) and is cleared whenever core_mode changes.
module mem_arb_pick
    import data_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic   clk,
    input  logic   rstn,
    input  logic   core_req,
    input  logic   io_req,
    input  logic   core_mode,
    input  logic   fire,
    output owner_t owner
);
    localparam int            CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q, cnt_eff, cnt_d;
    logic          mode_q, both, prio_win;
    owner_t        prio_own, other_own;

    always_comb begin
        prio_own  = core_mode ? OWN_CORE : OWN_IO;
        other_own = core_mode ? OWN_IO : OWN_CORE;
        both      = core_req & io_req;
        // A mode flip this cycle must already see a cleared count.
        cnt_eff   = (core_mode == mode_q) ? cnt_q : '0;

        owner = prio_own;
        if (both)          owner = (cnt_eff == LIMIT) ? other_own : prio_own;
        else if (core_req) owner = OWN_CORE;
        else if (io_req)   owner = OWN_IO;

        prio_win = both && (owner == prio_own);
        cnt_d    = cnt_eff;
        if (fire) cnt_d = prio_win ? ((cnt_eff == LIMIT) ? LIMIT : cnt_eff + CW'(1)) : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            mode_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= core_mode;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Registered arbiter sharing one data-memory port between core MEM stage and IO loader.
// IDLE -> BUSY (request held stable until mem_ready) -> DONE (one-cycle done pulse) -> IDLE.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rstn,
    data_mem_arbiter_if.slave bus,
    output logic              busy
);
    state_t            state_q, state_d;
    owner_t            owner_q, pick;
    logic              fire, complete;
    logic              valid_q, rw_q, core_done_q, io_done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q, core_rdata_q, io_rdata_q;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
        .clk       (clk),
        .rstn      (rstn),
        .core_req  (bus.core_req),
        .io_req    (bus.io_req),
        .core_mode (bus.core_mode),
        .fire      (fire),
        .owner     (pick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        fire     = 1'b0;
        complete = 1'b0;
        unique case (state_q)
            ST_IDLE: if (bus.core_req || bus.io_req) begin
                fire    = 1'b1;
                state_d = ST_BUSY;
            end
            ST_BUSY: if (bus.mem_ready) begin
                complete = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q      <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            owner_q      <= OWN_CORE;
            core_done_q  <= 1'b0;
            io_done_q    <= 1'b0;
            core_rdata_q <= '0;
            io_rdata_q   <= '0;
        end else begin
            core_done_q <= complete && (owner_q == OWN_CORE);
            io_done_q   <= complete && (owner_q == OWN_IO);
            if (fire) begin
                valid_q <= 1'b1;
                owner_q <= pick;
                if (pick == OWN_CORE) begin
                    rw_q   <= bus.core_we;
                    addr_q <= bus.core_addr;
                    din_q  <= bus.core_wdata;
                end else begin
                    rw_q   <= bus.io_we;
                    addr_q <= bus.io_addr;
                    din_q  <= bus.io_wdata;
                end
            end else if (complete) begin
                valid_q <= 1'b0;
                // Writes leave both read-data registers untouched.
                if (!rw_q) begin
                    if (owner_q == OWN_CORE) core_rdata_q <= bus.mem_dout;
                    else                     io_rdata_q   <= bus.mem_dout;
                end
            end
        end
    end

    assign bus.mem_valid  = valid_q;
    assign bus.mem_rw     = rw_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_din    = din_q;
    assign bus.core_done  = core_done_q;
    assign bus.io_done    = io_done_q;
    assign bus.core_rdata = core_rdata_q;
    assign bus.io_rdata   = io_rdata_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Transaction-level bench: directed scenarios plus randomized traffic against a grant/rdata model.
module tb_data_mem_arbiter;
    localparam int LIMIT = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .busy (busy)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          m_cnt  = 0;
    logic        m_mode = 1'b1;
    logic [31:0] m_rdata [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Grant rule at transaction level: returns 1 when IO should win.
    task automatic model_grant(input logic cr, input logic ir, input logic mode, output logic io_win);
        if (mode != m_mode) m_cnt = 0;
        m_mode = mode;
        if (cr && ir) io_win = (m_cnt == LIMIT) ? mode : !mode;
        else          io_win = ir;
        if (cr && ir && (io_win == !mode)) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
        else                               m_cnt = 0;
    endtask

    task automatic model_reset();
        m_cnt      = 0;
        m_mode     = 1'b1;
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;
    endtask

    // Entered at a negedge with the DUT in IDLE (from_done=0) or DONE (from_done=1).
    task automatic txn(input logic cr, input logic ir, input logic cwe, input logic iwe,
                       input logic [31:0] caddr, input logic [31:0] cdat,
                       input logic [31:0] iaddr, input logic [31:0] idat,
                       input int dly, input logic [31:0] dout,
                       input logic from_done, input logic scramble,
                       output logic [31:0] obs_addr);
        logic        iw, erw;
        logic [31:0] ea, ed;
        bus.core_req = cr;  bus.core_we = cwe; bus.core_addr = caddr; bus.core_wdata = cdat;
        bus.io_req   = ir;  bus.io_we   = iwe; bus.io_addr   = iaddr; bus.io_wdata   = idat;
        model_grant(cr, ir, bus.core_mode, iw);
        erw = iw ? iwe : cwe;
        ea  = iw ? iaddr : caddr;
        ed  = iw ? idat : cdat;
        if (from_done) begin
            @(negedge clk);
            chk("idle_valid", 32'(bus.mem_valid), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        @(negedge clk);
        obs_addr = bus.mem_addr;
        chk("grant_valid", 32'(bus.mem_valid), 32'd1);
        chk("grant_busy", 32'(busy), 32'd1);
        chk("grant_rw", 32'(bus.mem_rw), 32'(erw));
        chk("grant_addr", bus.mem_addr, ea);
        chk("grant_din", bus.mem_din, ed);
        for (int i = 0; i < dly; i++) begin
            if (scramble) begin
                bus.core_req  = 1'($urandom); bus.core_we = 1'($urandom);
                bus.core_addr = $urandom;     bus.core_wdata = $urandom;
                bus.io_req    = 1'($urandom); bus.io_we   = 1'($urandom);
                bus.io_addr   = $urandom;     bus.io_wdata   = $urandom;
            end
            @(negedge clk);
            chk("hold_valid", 32'(bus.mem_valid), 32'd1);
            chk("hold_rw", 32'(bus.mem_rw), 32'(erw));
            chk("hold_addr", bus.mem_addr, ea);
            chk("hold_din", bus.mem_din, ed);
            chk("hold_nodone", 32'({bus.core_done, bus.io_done}), 32'd0);
        end
        bus.mem_ready = 1'b1;
        bus.mem_dout  = dout;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_dout  = $urandom;
        if (!erw) m_rdata[iw] = dout;
        chk("done_core", 32'(bus.core_done), 32'(!iw));
        chk("done_io", 32'(bus.io_done), 32'(iw));
        chk("done_valid", 32'(bus.mem_valid), 32'd0);
        chk("core_rdata", bus.core_rdata, m_rdata[0]);
        chk("io_rdata", bus.io_rdata, m_rdata[1]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] oa;
        logic        fd, cr, ir;
        int          io_wins;
        bus.core_mode = 1'b1;
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.io_req   = 1'b0; bus.io_we   = 1'b0; bus.io_addr   = '0; bus.io_wdata   = '0;
        bus.mem_ready = 1'b0; bus.mem_dout = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'({bus.core_done, bus.io_done}), 32'd0);
        chk("rst_core_rdata", bus.core_rdata, 32'd0);
        chk("rst_io_rdata", bus.io_rdata, 32'd0);
        chk("rst_addr", bus.mem_addr, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Core read, ready on the third valid cycle.
        txn(1, 0, 0, 0, 32'h40, 0, 0, 0, 2, 32'hDEADBEEF, 0, 0, oa);
        chk("t1_core_rdata", bus.core_rdata, 32'hDEADBEEF);
        // Core write with request dropped and inputs scrambled during BUSY.
        txn(1, 0, 1, 0, 32'h4000, 32'h12345678, 0, 0, 2, 32'hCAFEF00D, 1, 1, oa);
        chk("t3_core_rdata_kept", bus.core_rdata, 32'hDEADBEEF);
        // IO read completing in the first valid cycle.
        txn(0, 1, 0, 0, 0, 0, 32'h80, 0, 0, 32'hA5A5A5A5, 1, 0, oa);
        chk("t4_io_rdata", bus.io_rdata, 32'hA5A5A5A5);
        chk("t4_core_rdata", bus.core_rdata, 32'hDEADBEEF);

        // Starvation: core wins LIMIT ties, IO takes the next one, then core again.
        for (int i = 0; i <= LIMIT + 1; i++) begin
            txn(1, 1, 1, 1, 32'h100, 32'(i), 32'h200, 32'(i), 0, 32'h0, 1, 0, oa);
            chk("starve_owner", oa, (i == LIMIT) ? 32'h200 : 32'h100);
        end
        bus.core_mode = 1'b0;
        for (int i = 0; i < 2; i++) begin
            txn(1, 1, 1, 1, 32'h100, 0, 32'h200, 0, 1, 32'h0, 1, 0, oa);
            chk("io_prio_owner", oa, 32'h200);
        end

        // Randomized traffic with idle gaps and stray mem_ready.
        fd = 1'b1;
        io_wins = 0;
        for (int t = 0; t < 120; t++) begin
            if ($urandom_range(0, 7) == 0) bus.core_mode = ~bus.core_mode;
            cr = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 3) != 0);
            if (!cr && !ir) cr = 1'b1;
            txn(cr, ir, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
                $urandom_range(0, 3), $urandom, fd, 1'($urandom), oa);
            fd = 1'b1;
            if ($urandom_range(0, 5) == 0) begin
                bus.core_req = 1'b0;
                bus.io_req   = 1'b0;
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    bus.mem_ready = 1'($urandom);
                    bus.mem_dout  = $urandom;
                    @(negedge clk);
                    chk("gap_valid", 32'(bus.mem_valid), 32'd0);
                    chk("gap_done", 32'({bus.core_done, bus.io_done}), 32'd0);
                    chk("gap_core_rdata", bus.core_rdata, m_rdata[0]);
                    chk("gap_io_rdata", bus.io_rdata, m_rdata[1]);
                end
                bus.mem_ready = 1'b0;
                fd = 1'b0;
            end
        end

        // Reset in the middle of BUSY, request kept pending across it.
        bus.core_mode = 1'b1;
        bus.io_req    = 1'b0;
        bus.core_req  = 1'b1; bus.core_we = 1'b0; bus.core_addr = 32'h300;
        if (fd) @(negedge clk);
        @(negedge clk);
        chk("mid_valid", 32'(bus.mem_valid), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.mem_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'({bus.core_done, bus.io_done}), 32'd0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        txn(1, 0, 0, 0, 32'h300, 0, 0, 0, 1, 32'h0BADF00D, 0, 0, oa);
        chk("rearb_addr", oa, 32'h300);
        chk("rearb_rdata", bus.core_rdata, 32'h0BADF00D);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
